conv_param: RTL and testbench

CONV_PARAM -- requirements
Module: conv_param

---
 rtl/conv_param_pkg.sv | 13 +
 rtl/conv_mac_lane.sv | 33 +++
 rtl/conv_param.sv | 108 ++++++++++
 tb/tb_conv_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_param_pkg.sv
// conv_param_pkg: FSM state, accumulator width and saturation bounds shared by conv_param and its lanes
package conv_param_pkg;
  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;
  function automatic int acc_w(input int t, input int m);
    return 2 * t + $clog2(m);
  endfunction
  function automatic longint sat_max(input int t);
    return (longint'(1) << (t - 1)) - 1;
  endfunction
  function automatic longint sat_min(input int t);
    return -(longint'(1) << (t - 1));
  endfunction
endpackage

// File: rtl/conv_mac_lane.sv
// conv_mac_lane: one MAC lane accumulating full-width x*f products and presenting a saturated T-bit result
// CONV_RELU_EN: when defined, negative saturated results are output as 0
module conv_mac_lane
  import conv_param_pkg::*;
#(
  parameter int M = 4,
  parameter int T = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic signed [T-1:0] x,
  input  logic signed [T-1:0] f,
  output logic signed [T-1:0] y
);
  localparam int AW = acc_w(T, M);
  localparam logic signed [AW-1:0] SMAX = AW'(sat_max(T));
  localparam logic signed [AW-1:0] SMIN = AW'(sat_min(T));
  logic signed [2*T-1:0] prod;
  logic signed [AW-1:0] acc;
  logic signed [T-1:0] sat;
  assign prod = (2*T)'(x) * (2*T)'(f);
  always_ff @(posedge clk)
    if (rst || clr) acc <= '0;
    else if (en) acc <= acc + AW'(prod);
  always_comb sat = acc > SMAX ? T'(SMAX) : acc < SMIN ? T'(SMIN) : T'(acc);
`ifdef CONV_RELU_EN
  assign y = sat[T-1] ? '0 : sat;
`else
  assign y = sat;
`endif
endmodule

// File: rtl/conv_param.sv
// conv_param: valid 1-D convolution of an N-word vector with an M-word filter, P outputs per COMPUTE group
// CONV_RELU_EN: when defined, negative results are output as 0
module conv_param
  import conv_param_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4,
  parameter int T = 8,
  parameter int P = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] s_data_in_x,
  input  logic                s_valid_x,
  output logic                s_ready_x,
  input  logic signed [T-1:0] s_data_in_f,
  input  logic                s_valid_f,
  output logic                s_ready_f,
  output logic signed [T-1:0] m_data_out_y,
  output logic                m_valid_y,
  input  logic                m_ready_y
);
  localparam int NO = N - M + 1;
  localparam int AW = $clog2(N);
  localparam int FW = $clog2(M);
  localparam int XW = $clog2(N + 1);
  localparam int FCW = $clog2(M + 1);
  localparam int CW = $clog2(M + 2);
  localparam int DW = $clog2(P + 1);
  state_t state;
  logic [XW-1:0] xc, k;
  logic [FCW-1:0] fc;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dcnt;
  logic signed [T-1:0] xm [N];
  logic signed [T-1:0] fm [M];
  logic [P*T-1:0] lane_y, res;
  logic x_full, f_full, lane_clr, lane_en;
  assign x_full = xc == XW'(N);
  assign f_full = fc == FCW'(M);
  assign s_ready_x = !reset && state == LOAD && !x_full;
  assign s_ready_f = !reset && state == LOAD && !f_full;
  assign m_data_out_y = res[T-1:0];
  // cnt 0 clears, 1..M accumulate tap cnt-1, M+1 captures the saturated results
  assign lane_clr = state == COMPUTE && cnt == '0;
  assign lane_en = state == COMPUTE && cnt != '0 && cnt != CW'(M + 1);
  always_ff @(posedge clk) begin
    if (s_valid_x && s_ready_x) xm[AW'(xc)] <= s_data_in_x;
    if (s_valid_f && s_ready_f) fm[FW'(fc)] <= s_data_in_f;
  end
  for (genvar j = 0; j < P; j++) begin : g_lane
    conv_mac_lane #(.M(M), .T(T)) u_lane (
      .clk(clk),
      .rst(reset),
      .clr(lane_clr),
      .en(lane_en),
      .x(xm[AW'(32'(k) + 32'(cnt) + j - 1)]),
      .f(fm[FW'(32'(cnt) - 1)]),
      .y(lane_y[j*T +: T])
    );
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= LOAD;
      xc <= '0;
      fc <= '0;
      k <= '0;
      cnt <= '0;
      dcnt <= '0;
      m_valid_y <= 1'b0;
      res <= '0;
    end else case (state)
      LOAD: begin
        if (s_valid_x && s_ready_x) xc <= xc + XW'(1);
        if (s_valid_f && s_ready_f) fc <= fc + FCW'(1);
        if (x_full && f_full) begin
          state <= COMPUTE;
          k <= '0;
          cnt <= '0;
        end
      end
      COMPUTE: begin
        cnt <= cnt + CW'(1);
        if (cnt == CW'(M + 1)) begin
          state <= DRAIN;
          res <= lane_y;
          dcnt <= '0;
          m_valid_y <= 1'b1;
        end
      end
      default: if (m_ready_y) begin
        res <= res >> T;
        dcnt <= dcnt + DW'(1);
        if (dcnt == DW'(P - 1)) begin
          m_valid_y <= 1'b0;
          cnt <= '0;
          if (k + XW'(P) < XW'(NO)) begin
            state <= COMPUTE;
            k <= k + XW'(P);
          end else begin
            state <= LOAD;
            xc <= '0;
            fc <= '0;
          end
        end
      end
    endcase
endmodule

// File: tb/tb_conv_param.sv
// tb_conv_param: table-driven scoreboard bench running a P=1 and a P=5 conv_param side by side
`timescale 1ns/1ps
module tb_conv_param;
  localparam int N = 8, M = 4, T = 8;
  typedef struct {
    logic [7:0][7:0] x;
    logic [3:0][7:0] f;
    logic [4:0][7:0] y;
    int mode;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1;
  logic signed [T-1:0] dx = '0, df = '0;
  logic vx = 1'b0, vf = 1'b0, m_ready = 1'b1;
  logic rx1, rf1, v1, rx5, rf5, v5;
  logic signed [T-1:0] y1, y5;
  logic signed [T-1:0] q1[$], q5[$];
  int n_tests = 0, n_fail = 0, cyc = 0, last1 = -1, last5 = -1;
  bit gap_chk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  conv_param #(.N(N), .M(M), .T(T), .P(1)) u1 (
    .clk(clk), .reset(reset),
    .s_data_in_x(dx), .s_valid_x(vx), .s_ready_x(rx1),
    .s_data_in_f(df), .s_valid_f(vf), .s_ready_f(rf1),
    .m_data_out_y(y1), .m_valid_y(v1), .m_ready_y(m_ready)
  );
  conv_param #(.N(N), .M(M), .T(T), .P(5)) u5 (
    .clk(clk), .reset(reset),
    .s_data_in_x(dx), .s_valid_x(vx), .s_ready_x(rx5),
    .s_data_in_f(df), .s_valid_f(vf), .s_ready_f(rf5),
    .m_data_out_y(y5), .m_valid_y(v5), .m_ready_y(m_ready)
  );
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask
  function automatic logic [7:0][7:0] p8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction
  function automatic logic [3:0][7:0] p4(input int a0, a1, a2, a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction
  function automatic logic [4:0][7:0] p5(input int a0, a1, a2, a3, a4);
    return {8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction
  function automatic logic signed [7:0] exp_y(input logic signed [7:0] y);
`ifdef CONV_RELU_EN
    return y < 0 ? 8'sd0 : y;
`else
    return y;
`endif
  endfunction
  // Scoreboard pops happen on the negedge before the accepting posedge.
  always @(negedge clk) if (!reset && m_ready) begin
    if (v1) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL y1_extra: got %0d, required no word", y1);
      end else begin
        chk("y1", y1, q1.pop_front());
        if (gap_chk && last1 >= 0) chk("gap1", cyc - last1, M + 3);
        last1 = q1.size() == 0 ? -1 : cyc;
      end
    end
    if (v5) begin
      if (q5.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL y5_extra: got %0d, required no word", y5);
      end else begin
        chk("y5", y5, q5.pop_front());
        if (gap_chk && last5 >= 0) chk("gap5", cyc - last5, 1);
        last5 = q5.size() == 0 ? -1 : cyc;
      end
    end
  end
  task automatic load(input vec_t v, input bit push);
    int xi = 0, fi = 0, n = 0;
    while ((xi < N || fi < M) && n < 300) begin
      @(negedge clk);
      n++;
      vx = xi < N ? (v.mode != 2 || $urandom_range(0, 1) == 1) : (v.mode == 1);
      dx = xi < N ? v.x[xi] : 8'sh5a;
      vf = fi < M && (v.mode == 0 || (v.mode == 1 && xi == N) || (v.mode == 2 && $urandom_range(0, 1) == 1));
      df = fi < M ? v.f[fi] : 8'sh5a;
      if (vx && rx1 && xi < N) xi++;
      if (vf && rf1) fi++;
    end
    if (xi < N || fi < M) begin
      n_tests++;
      n_fail++;
      $display("FAIL load_timeout: got %0d/%0d words, required %0d/%0d", xi, fi, N, M);
    end
    if (push) for (int i = 0; i < 5; i++) begin
      q1.push_back(exp_y(v.y[i]));
      q5.push_back(exp_y(v.y[i]));
    end
    repeat (5) begin
      @(negedge clk);
      vx = 1'b1;
      vf = 1'b1;
      dx = 8'sh5a;
      df = -8'sd77;
    end
    @(negedge clk);
    vx = 1'b0;
    vf = 1'b0;
  endtask
  task automatic drain(input string nm);
    int n = 0;
    while ((q1.size() != 0 || q5.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d/%0d words pending, required 0", nm, q1.size(), q5.size());
      q1.delete();
      q5.delete();
    end
    @(negedge clk);
    chk({nm, "_rdy_x1"}, rx1, 1);
    chk({nm, "_rdy_f1"}, rf1, 1);
    chk({nm, "_rdy_x5"}, rx5, 1);
    chk({nm, "_rdy_f5"}, rf5, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tv[6];
    int n;
    tv[0] = '{p8(1, 2, 3, 4, 5, 6, 7, 8), p4(1, 1, 1, 1), p5(10, 14, 18, 22, 26), 0};
    tv[1] = '{p8(127, 127, 127, 127, 127, 127, 127, 127), p4(127, 127, 127, 127), p5(127, 127, 127, 127, 127), 1};
    tv[2] = '{p8(-128, -128, -128, -128, -128, -128, -128, -128), p4(127, 127, 127, 127), p5(-128, -128, -128, -128, -128), 2};
    tv[3] = '{p8(1, 2, 3, 4, 5, 6, 7, 8), p4(-1, -1, -1, -1), p5(-10, -14, -18, -22, -26), 2};
    tv[4] = '{p8(3, -5, 7, -2, 100, -90, 50, 1), p4(2, -3, 1, 4), p5(20, 127, -128, -128, 127), 0};
    tv[5] = '{p8(10, -20, 30, -40, 5, 6, -7, 8), p4(1, 0, -1, 1), p5(-60, 25, 31, -53, 20), 1};
    repeat (3) @(negedge clk);
    chk("rst_rdy_x", rx1, 0);
    chk("rst_rdy_f", rf1, 0);
    chk("rst_valid", v1, 0);
    chk("rst_data", y1, 0);
    chk("rst_valid5", v5, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_rdy_x", rx1, 1);
    chk("post_rst_rdy_f", rf1, 1);
    @(negedge clk);
    chk("post_rst_rdy_x_edge", rx1, 1);
    chk("post_rst_rdy_f_edge", rf5, 1);
    for (int i = 0; i < 6; i++) begin
      gap_chk = i == 0;
      load(tv[i], 1'b1);
      drain($sformatf("v%0d", i));
    end
    gap_chk = 1'b0;
    load(tv[0], 1'b1);
    n = 0;
    while (q1.size() > 3 && n < 500) begin
      @(posedge clk);
      n++;
    end
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!v1 && n < 50);
    m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", v1, 1);
      chk("stall_data", y1, q1.size() > 0 ? int'(q1[0]) : 999);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    drain("stall");
    load(tv[0], 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_rdy_x", rx1, 0);
    chk("midrst_valid", v1, 0);
    chk("midrst_data", y1, 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_quiet1", v1, 0);
    chk("midrst_quiet5", v5, 0);
    load(tv[0], 1'b1);
    drain("after_rst");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
